pwm_generate: RTL and testbench

PWM_GENERATE -- requirements
Module: pwm_generate

---
 rtl/pwm_pkg.sv | 14 +
 rtl/pwm_shadow_reg.sv | 74 +++++++
 rtl/pwm_generate.sv | 138 +++++++++++++
 tb/tb_pwm_generate.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// pwm_pkg -- shared definitions for the PWM generator family.
//   pwm_state_e        : generator state (IDLE / HIGH / LOW)
//   PWM_CNT_W_DEFAULT  : default width of count ports and count registers
package pwm_pkg;

  localparam int unsigned PWM_CNT_W_DEFAULT = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } pwm_state_e;

endpackage

// File: rtl/pwm_shadow_reg.sv
// pwm_shadow_reg -- shadow/active duration register pair with pending flag.
//   clk, rst_n            : clock, asynchronous active-low reset
//   load                  : capture high_in/low_in into the shadow registers
//   apply                 : period start; active <= eff, pending cleared
//   high_in, low_in       : requested durations
//   active_high/low       : durations governing the current period
//   eff_high/low          : durations that a period starting now would use
//                           (load bypass > pending shadow > current active)
//   pending               : a captured load is waiting for a period start
module pwm_shadow_reg
  import pwm_pkg::*;
#(
  parameter int unsigned CNT_W = PWM_CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             apply,
  input  logic [CNT_W-1:0] high_in,
  input  logic [CNT_W-1:0] low_in,
  output logic [CNT_W-1:0] active_high,
  output logic [CNT_W-1:0] active_low,
  output logic [CNT_W-1:0] eff_high,
  output logic [CNT_W-1:0] eff_low,
  output logic             pending
);

  logic [CNT_W-1:0] shadow_high_q, shadow_high_d;
  logic [CNT_W-1:0] shadow_low_q,  shadow_low_d;
  logic [CNT_W-1:0] active_high_q, active_high_d;
  logic [CNT_W-1:0] active_low_q,  active_low_d;
  logic             pending_q,     pending_d;

  always_comb begin
    // A load coinciding with a period start governs that new period.
    if (load) begin
      eff_high = high_in;
      eff_low  = low_in;
    end else if (pending_q) begin
      eff_high = shadow_high_q;
      eff_low  = shadow_low_q;
    end else begin
      eff_high = active_high_q;
      eff_low  = active_low_q;
    end

    shadow_high_d = load ? high_in : shadow_high_q;
    shadow_low_d  = load ? low_in  : shadow_low_q;
    active_high_d = apply ? eff_high : active_high_q;
    active_low_d  = apply ? eff_low  : active_low_q;
    pending_d     = apply ? 1'b0 : (pending_q | load);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_high_q <= '0;
      shadow_low_q  <= '0;
      active_high_q <= '0;
      active_low_q  <= '0;
      pending_q     <= 1'b0;
    end else begin
      shadow_high_q <= shadow_high_d;
      shadow_low_q  <= shadow_low_d;
      active_high_q <= active_high_d;
      active_low_q  <= active_low_d;
      pending_q     <= pending_d;
    end
  end

  assign active_high = active_high_q;
  assign active_low  = active_low_q;
  assign pending     = pending_q;

endmodule

// File: rtl/pwm_generate.sv
// pwm_generate -- programmable PWM generator with period-boundary reload.
//   pwd_clk        : rising-edge clock
//   sysreset       : asynchronous active-low reset
//   enable         : 1 runs the generator, 0 forces idle
//   load           : strobe capturing high_count_in / low_count_in
//   high_count_in  : requested high duration (cycles)
//   low_count_in   : requested low duration (cycles)
//   pwm_out        : registered PWM waveform
//   period_done    : registered pulse on the last cycle of each period
//   period_count   : periods completed (only with PWM_GEN_PERIOD_CNT_EN)
//   pending        : a captured load awaits the next period start
// Optional feature macro: PWM_GEN_PERIOD_CNT_EN adds the period_count port.
module pwm_generate
  import pwm_pkg::*;
#(
  parameter int unsigned CNT_W            = PWM_CNT_W_DEFAULT,
  parameter bit          RESET_VALUE_HIGH = 1'b0
) (
  input  logic             pwd_clk,
  input  logic             sysreset,
  input  logic             enable,
  input  logic             load,
  input  logic [CNT_W-1:0] high_count_in,
  input  logic [CNT_W-1:0] low_count_in,
  output logic             pwm_out,
  output logic             period_done,
`ifdef PWM_GEN_PERIOD_CNT_EN
  output logic [CNT_W-1:0] period_count,
`endif
  output logic             pending
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  pwm_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pwm_out_q, pwm_out_d;
  logic             period_done_q, period_done_d;

  logic [CNT_W-1:0] active_high, active_low;
  logic [CNT_W-1:0] eff_high, eff_low;
  logic [CNT_W-1:0] nxt_high, nxt_low;
  logic             hi_last, lo_last, period_end, degenerate, apply;

  pwm_shadow_reg #(
    .CNT_W (CNT_W)
  ) u_shadow (
    .clk         (pwd_clk),
    .rst_n       (sysreset),
    .load        (load),
    .apply       (apply),
    .high_in     (high_count_in),
    .low_in      (low_count_in),
    .active_high (active_high),
    .active_low  (active_low),
    .eff_high    (eff_high),
    .eff_low     (eff_low),
    .pending     (pending)
  );

  always_comb begin
    hi_last    = (cnt_q == (active_high - ONE));
    lo_last    = (cnt_q == (active_low - ONE));
    // Zero low duration: HIGH alone forms the whole period.
    period_end = ((state_q == HIGH) && (active_low == '0) && hi_last) ||
                 ((state_q == LOW)  && (active_low != '0) && lo_last);
    // Both durations zero park in LOW with nothing to count; every cycle is
    // a silent period start so a pending load takes effect promptly.
    degenerate = (state_q == LOW) && (active_low == '0);
    apply      = enable && ((state_q == IDLE) || period_end || degenerate);

    state_d = state_q;
    cnt_d   = cnt_q;
    if (!enable) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (apply) begin
      cnt_d   = '0;
      state_d = (eff_high != '0) ? HIGH : LOW;
    end else if ((state_q == HIGH) && hi_last) begin
      state_d = LOW;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + ONE;
    end

    nxt_high = apply ? eff_high : active_high;
    nxt_low  = apply ? eff_low  : active_low;

    // Outputs are decoded from next-state values so the registered outputs
    // line up with the state they describe.
    unique case (state_d)
      HIGH:    pwm_out_d = 1'b1;
      LOW:     pwm_out_d = 1'b0;
      default: pwm_out_d = RESET_VALUE_HIGH;
    endcase

    period_done_d =
      ((state_d == HIGH) && (nxt_low == '0) && (cnt_d == (nxt_high - ONE))) ||
      ((state_d == LOW)  && (nxt_low != '0) && (cnt_d == (nxt_low - ONE)));
  end

  always_ff @(posedge pwd_clk or negedge sysreset) begin
    if (!sysreset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      pwm_out_q     <= RESET_VALUE_HIGH;
      period_done_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      pwm_out_q     <= pwm_out_d;
      period_done_q <= period_done_d;
    end
  end

  assign pwm_out     = pwm_out_q;
  assign period_done = period_done_q;

`ifdef PWM_GEN_PERIOD_CNT_EN
  logic [CNT_W-1:0] period_count_q, period_count_d;

  always_comb begin
    period_count_d = period_count_q + (period_done_q ? ONE : '0);
  end

  always_ff @(posedge pwd_clk or negedge sysreset) begin
    if (!sysreset) begin
      period_count_q <= '0;
    end else begin
      period_count_q <= period_count_d;
    end
  end

  assign period_count = period_count_q;
`endif

endmodule

// File: tb/tb_pwm_generate.sv
module tb_pwm_generate;

  localparam int unsigned CNT_W = 4;

  logic             pwd_clk = 1'b0;
  logic             sysreset = 1'b0;
  logic             enable = 1'b0;
  logic             load = 1'b0;
  logic [CNT_W-1:0] high_count_in = '0;
  logic [CNT_W-1:0] low_count_in = '0;
  logic             pwm_out, period_done, pending;
`ifdef PWM_GEN_PERIOD_CNT_EN
  logic [CNT_W-1:0] period_count;
`endif

  pwm_generate #(
    .CNT_W            (CNT_W),
    .RESET_VALUE_HIGH (1'b0)
  ) dut (
    .pwd_clk       (pwd_clk),
    .sysreset      (sysreset),
    .enable        (enable),
    .load          (load),
    .high_count_in (high_count_in),
    .low_count_in  (low_count_in),
    .pwm_out       (pwm_out),
    .period_done   (period_done),
`ifdef PWM_GEN_PERIOD_CNT_EN
    .period_count  (period_count),
`endif
    .pending       (pending)
  );

  always #5 pwd_clk = ~pwd_clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: position within the current period plus the
  // active/shadow duration sets.
  int unsigned m_h, m_l, m_sh, m_sl, m_pos, m_pc;
  bit          m_pend, m_run, m_pwm, m_pd;

  task automatic model_reset();
    m_h = 0; m_l = 0; m_sh = 0; m_sl = 0; m_pos = 0; m_pc = 0;
    m_pend = 0; m_run = 0; m_pwm = 0; m_pd = 0;
  endtask

  task automatic model_step();
    int unsigned eh, el;
    bit start;
    if (m_pd) m_pc = (m_pc + 1) % (1 << CNT_W);
    if (!enable) begin
      m_run = 0;
      if (load) begin m_sh = high_count_in; m_sl = low_count_in; m_pend = 1; end
      m_pwm = 0;
      m_pd  = 0;
    end else begin
      start = !m_run || (m_h + m_l == 0) || (m_pos == m_h + m_l - 1);
      if (start) begin
        if (load) begin eh = high_count_in; el = low_count_in; end
        else if (m_pend) begin eh = m_sh; el = m_sl; end
        else begin eh = m_h; el = m_l; end
        m_h = eh; m_l = el; m_pend = 0; m_pos = 0; m_run = 1;
        if (load) begin m_sh = high_count_in; m_sl = low_count_in; end
      end else begin
        m_pos++;
        if (load) begin m_sh = high_count_in; m_sl = low_count_in; m_pend = 1; end
      end
      m_pwm = (m_pos < m_h);
      m_pd  = (m_h + m_l != 0) && (m_pos == m_h + m_l - 1);
    end
  endtask

  // Advance one clock, update the model, settle, release the load strobe.
  task automatic cycle();
    @(posedge pwd_clk);
    if (!sysreset) model_reset();
    else model_step();
    #1;
    load = 1'b0;
  endtask

  task automatic do_load(input int unsigned h, input int unsigned l);
    high_count_in = h[CNT_W-1:0];
    low_count_in  = l[CNT_W-1:0];
    load = 1'b1;
    cycle();
  endtask

  task automatic test_reset();
    model_reset();
    sysreset = 1'b0;
    #3;
    n_vec++;
    if (pwm_out !== 1'b0) begin n_err++; $display("FAIL reset_pwm got %0b exp 0", pwm_out); end
    n_vec++;
    if (period_done !== 1'b0) begin n_err++; $display("FAIL reset_pd got %0b exp 0", period_done); end
    n_vec++;
    if (pending !== 1'b0) begin n_err++; $display("FAIL reset_pending got %0b exp 0", pending); end
    cycle(); cycle();
    @(negedge pwd_clk);
    sysreset = 1'b1;
    cycle();
  endtask

  task automatic test_basic();
    bit pat [8] = '{1, 1, 1, 0, 0, 0, 0, 0};
    do_load(3, 5);
    n_vec++;
    if (pending !== 1'b1) begin n_err++; $display("FAIL basic_pending got %0b exp 1", pending); end
    enable = 1'b1;
    for (int i = 0; i < 24; i++) begin
      cycle();
      n_vec++;
      if (pwm_out !== pat[i % 8] || pwm_out !== m_pwm) begin
        n_err++; $display("FAIL basic_pwm cyc %0d got %0b exp %0b", i, pwm_out, pat[i % 8]);
      end
      n_vec++;
      if (period_done !== (i % 8 == 7)) begin
        n_err++; $display("FAIL basic_pd cyc %0d got %0b exp %0b", i, period_done, (i % 8 == 7));
      end
    end
  endtask

  task automatic test_reload();
    cycle();            // first HIGH cycle of a 3/5 period
    do_load(6, 2);      // captured mid-HIGH
    n_vec++;
    if (pending !== 1'b1) begin n_err++; $display("FAIL reload_pending got %0b exp 1", pending); end
    for (int i = 0; i < 24; i++) begin
      cycle();
      n_vec++;
      if (pwm_out !== m_pwm) begin n_err++; $display("FAIL reload_pwm cyc %0d got %0b exp %0b", i, pwm_out, m_pwm); end
      n_vec++;
      if (period_done !== m_pd) begin n_err++; $display("FAIL reload_pd cyc %0d got %0b exp %0b", i, period_done, m_pd); end
      n_vec++;
      if (pending !== m_pend) begin n_err++; $display("FAIL reload_pending cyc %0d got %0b exp %0b", i, pending, m_pend); end
    end
  endtask

  task automatic test_zero_counts();
    int unsigned hs [4] = '{0, 4, 0, 2};
    int unsigned ls [4] = '{4, 0, 0, 1};
    for (int k = 0; k < 4; k++) begin
      do_load(hs[k], ls[k]);
      for (int i = 0; i < 20; i++) begin
        cycle();
        n_vec++;
        if (pwm_out !== m_pwm) begin n_err++; $display("FAIL zero%0d_pwm cyc %0d got %0b exp %0b", k, i, pwm_out, m_pwm); end
        n_vec++;
        if (period_done !== m_pd) begin n_err++; $display("FAIL zero%0d_pd cyc %0d got %0b exp %0b", k, i, period_done, m_pd); end
        n_vec++;
        if (pending !== m_pend) begin n_err++; $display("FAIL zero%0d_pending cyc %0d got %0b exp %0b", k, i, pending, m_pend); end
      end
    end
  endtask

  task automatic test_enable_drop();
    int guard = 0;
    do_load(3, 5);
    while (!m_pd && guard < 40) begin cycle(); guard++; end
    n_vec++;
    if (guard >= 40) begin n_err++; $display("FAIL drop_wait got timeout exp period_done"); end
    cycle();            // HIGH cycle 1 of 3/5
    cycle();            // HIGH cycle 2
    enable = 1'b0;
    cycle();
    n_vec++;
    if (pwm_out !== 1'b0) begin n_err++; $display("FAIL drop_pwm got %0b exp 0", pwm_out); end
    n_vec++;
    if (period_done !== 1'b0) begin n_err++; $display("FAIL drop_pd got %0b exp 0", period_done); end
    cycle();
    enable = 1'b1;
    for (int i = 0; i < 12; i++) begin
      cycle();
      n_vec++;
      if (pwm_out !== m_pwm || pwm_out !== (i % 8 < 3)) begin
        n_err++; $display("FAIL drop_rerun_pwm cyc %0d got %0b exp %0b", i, pwm_out, m_pwm);
      end
      n_vec++;
      if (period_done !== m_pd) begin n_err++; $display("FAIL drop_rerun_pd cyc %0d got %0b exp %0b", i, period_done, m_pd); end
    end
  endtask

  task automatic test_reset_mid_low();
    int guard = 0;
    while (!(m_run && m_pos == 4) && guard < 40) begin cycle(); guard++; end
    n_vec++;
    if (guard >= 40) begin n_err++; $display("FAIL rstlow_wait got timeout exp LOW phase"); end
    do_load(7, 7);
    n_vec++;
    if (pending !== 1'b1) begin n_err++; $display("FAIL rstlow_pending_pre got %0b exp 1", pending); end
    #2;
    sysreset = 1'b0;
    model_reset();
    #1;
    n_vec++;
    if (pwm_out !== 1'b0) begin n_err++; $display("FAIL rstlow_pwm got %0b exp 0", pwm_out); end
    n_vec++;
    if (pending !== 1'b0) begin n_err++; $display("FAIL rstlow_pending got %0b exp 0", pending); end
    n_vec++;
    if (period_done !== 1'b0) begin n_err++; $display("FAIL rstlow_pd got %0b exp 0", period_done); end
    cycle();
    @(negedge pwd_clk);
    sysreset = 1'b1;
    for (int i = 0; i < 12; i++) begin
      cycle();
      n_vec++;
      if (pwm_out !== 1'b0) begin n_err++; $display("FAIL rstlow_idle_pwm cyc %0d got %0b exp 0", i, pwm_out); end
      n_vec++;
      if (period_done !== 1'b0) begin n_err++; $display("FAIL rstlow_idle_pd cyc %0d got %0b exp 0", i, period_done); end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      enable = ($urandom_range(0, 15) != 0);
      if ($urandom_range(0, 5) == 0) begin
        high_count_in = CNT_W'($urandom_range(0, 15));
        low_count_in  = CNT_W'($urandom_range(0, 15));
        load = 1'b1;
      end
      cycle();
      n_vec++;
      if (pwm_out !== m_pwm) begin n_err++; $display("FAIL rand_pwm cyc %0d got %0b exp %0b", i, pwm_out, m_pwm); end
      n_vec++;
      if (period_done !== m_pd) begin n_err++; $display("FAIL rand_pd cyc %0d got %0b exp %0b", i, period_done, m_pd); end
      n_vec++;
      if (pending !== m_pend) begin n_err++; $display("FAIL rand_pending cyc %0d got %0b exp %0b", i, pending, m_pend); end
    end
  endtask

`ifdef PWM_GEN_PERIOD_CNT_EN
  task automatic test_period_count();
    int unsigned seen [$];
    enable = 1'b0;
    sysreset = 1'b0;
    model_reset();
    cycle();
    @(negedge pwd_clk);
    sysreset = 1'b1;
    do_load(1, 1);
    enable = 1'b1;
    for (int i = 0; i < 40; i++) begin
      cycle();
      n_vec++;
      if (period_count !== CNT_W'(m_pc)) begin
        n_err++; $display("FAIL pcount cyc %0d got %0d exp %0d", i, period_count, m_pc);
      end
      if (seen.size() == 0 || seen[$] != period_count) seen.push_back(period_count);
    end
    n_vec++;
    if (seen.size() < 17 || seen[14] != 14 || seen[15] != 15 || seen[16] != 0) begin
      n_err++; $display("FAIL pcount_wrap got %0d values exp 14,15,0 at 14..16", seen.size());
    end
    enable = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_reload();
    test_zero_counts();
    test_enable_drop();
    test_reset_mid_low();
    test_random();
`ifdef PWM_GEN_PERIOD_CNT_EN
    test_period_count();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog expired");
  end

endmodule
